// File: rtl/rvm_sram_axi4_bridge.sv
// rvm_sram_axi4_bridge
//
// Connects the core's SRAM-style memory port to a single-beat AXI4 master.
// Only one transaction is in flight at a time, and the core is held with
// mem_stall until that transaction completes. Completion is the single DONE
// cycle: mem_stall is low, mem_rdata holds the read data and mem_error holds
// the response status.
//
// Optional feature: when AXI_WR_POSTED_EN is defined, writes are posted. A
// write completes as soon as its AW and W handshakes have finished. The B
// response is then collected in the background, and an error response sets
// bus_err_sticky. Any new request waits in IDLE until that response arrives.
// When the macro is undefined, writes wait for B and bus_err_sticky is tied 0.
//
// Ports
//   ACLK, ARESET        single clock; synchronous active-high reset
//   mem_addr/wdata      core request address and write data
//   mem_c_en            core request valid, held until mem_stall is low
//   mem_w_en            1 = write, 0 = read
//   mem_b_en            write byte enables
//   mem_rdata           read data, valid in the completion cycle and held
//   mem_error           response error, valid in the completion cycle
//   mem_stall           core must hold its request while this is high
//   M_AXI_AR*/R*        AXI4 read address and read data channels
//   M_AXI_AW*/W*/B*     AXI4 write address, write data and write response
//   bus_err_sticky      posted-write error flag; cleared only by ARESET
module rvm_sram_axi4_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_c_en,
  input  logic                mem_w_en,
  input  logic [DATA_W/8-1:0] mem_b_en,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_error,
  output logic                mem_stall,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  output logic [2:0]          M_AXI_ARSIZE,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  output logic [2:0]          M_AXI_AWSIZE,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic                bus_err_sticky
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_LOG = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                aw_done, w_done;
  logic                accept;
  logic                hold_new;

  // Every access is a full-width beat, so the address is aligned to the bus
  // width and the transfer size always covers the whole bus.
  assign M_AXI_ARADDR = addr_q & ~ADDR_W'(STRB_W - 1);
  assign M_AXI_AWADDR = M_AXI_ARADDR;
  assign M_AXI_ARSIZE = 3'(SIZE_LOG);
  assign M_AXI_AWSIZE = 3'(SIZE_LOG);
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = strb_q;
  assign mem_rdata    = rdata_q;
  assign mem_error    = err_q;

`ifdef AXI_WR_POSTED_EN
  logic b_pending;
  logic sticky_q;
  assign hold_new       = b_pending;
  assign bus_err_sticky = sticky_q;
`else
  assign hold_new       = 1'b0;
  assign bus_err_sticky = 1'b0;
`endif

  // Next-state and handshake decode. All valid/ready outputs come from
  // registered state and flags, so they stay stable until a handshake occurs.
  always_comb begin
    state_next    = state;
    mem_stall     = 1'b1;
    accept        = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = mem_c_en;
        if (mem_c_en && !hold_new) begin
          accept     = 1'b1;
          state_next = mem_w_en ? WREQ : RADDR;
        end
      end
      RADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_next = RDATA;
      end
      RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_next = DONE;
      end
      WREQ: begin
        // AW and W finish independently; leave WREQ once both have finished.
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) begin
`ifdef AXI_WR_POSTED_EN
          state_next = DONE;
`else
          state_next = WRESP;
`endif
        end
      end
      WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_next = DONE;
      end
      DONE: begin
        mem_stall  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef AXI_WR_POSTED_EN
    // With posted writes, the B response is accepted whenever one is owed.
    M_AXI_BREADY = b_pending;
`endif
  end

  // State register, request capture and response capture. mem_error is
  // valid for the single DONE cycle only and is cleared as DONE is left.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        strb_q  <= mem_b_en;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WREQ) begin
        if (M_AXI_AWREADY) aw_done <= 1'b1;
        if (M_AXI_WREADY)  w_done  <= 1'b1;
      end
      if (state == RDATA && M_AXI_RVALID) begin
        rdata_q <= M_AXI_RDATA;
        err_q   <= (M_AXI_RRESP != 2'b00);
      end
      if (state == WRESP && M_AXI_BVALID) err_q <= (M_AXI_BRESP != 2'b00);
      if (state == DONE) err_q <= 1'b0;
    end
  end

`ifdef AXI_WR_POSTED_EN
  // A posted write owes one B response. A new request is not accepted until
  // that response arrives, so at most one response is ever outstanding.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      b_pending <= 1'b0;
      sticky_q  <= 1'b0;
    end else if (state == WREQ && state_next == DONE) begin
      b_pending <= 1'b1;
    end else if (b_pending && M_AXI_BVALID) begin
      b_pending <= 1'b0;
      if (M_AXI_BRESP != 2'b00) sticky_q <= 1'b1;
    end
  end
`endif

endmodule
